// File: rtl/spi_transaction_arbiter.sv
// Round-robin arbiter sharing one quick_spi master between two requesters,
// with a per-transaction timeout and a programmable idle gap afterwards.
module spi_transaction_arbiter #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int GAP_CYCLES     = 4,
    parameter int CNT_WIDTH      = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_slave,
    input  logic [1:0]  req_operation,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    output logic        rsp_error,
    output logic [7:0]  rsp_data,
    output logic        busy,
    output logic        spi_enable,
    output logic        spi_start_transaction,
    output logic [1:0]  spi_slave,
    output logic [15:0] spi_outgoing_data,
    output logic        spi_operation,
    input  logic        spi_end_of_transaction,
    input  logic [7:0]  spi_incoming_data
);

    typedef enum logic [1:0] {IDLE, BUSY, GAP} state_t;

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST     = CNT_WIDTH'(GAP_CYCLES - 1);

    state_t               state, state_next;
    logic [CNT_WIDTH-1:0] cnt, cnt_next;
    logic                 last_grant;
    logic                 grant;
    logic                 accept;
    logic                 finish;
    logic                 timed_out;

    assign busy = (state != IDLE);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        grant      = last_grant;
        accept     = 1'b0;
        finish     = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    accept     = 1'b1;
                    grant      = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
                    state_next = BUSY;
                    cnt_next   = '0;
                end
            end
            BUSY: begin
                // A completion arriving on the timeout cycle still counts as success.
                if (spi_end_of_transaction) begin
                    finish = 1'b1;
                end else if (cnt == TIMEOUT_LAST) begin
                    finish    = 1'b1;
                    timed_out = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
                if (finish) begin
                    cnt_next   = '0;
                    state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                last_grant <= grant;
            end
        end
    end

    // During BUSY last_grant names the requester that owns the transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_ready             <= '0;
            rsp_valid             <= '0;
            rsp_error             <= 1'b0;
            rsp_data              <= '0;
            spi_enable            <= 1'b0;
            spi_start_transaction <= 1'b0;
            spi_slave             <= '0;
            spi_outgoing_data     <= '0;
            spi_operation         <= 1'b0;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            if (accept) begin
                req_ready             <= grant ? 2'b10 : 2'b01;
                spi_enable            <= 1'b1;
                spi_start_transaction <= 1'b1;
                spi_outgoing_data     <= grant ? req_data[31:16] : req_data[15:0];
                spi_slave             <= grant ? req_slave[3:2] : req_slave[1:0];
                spi_operation         <= grant ? req_operation[1] : req_operation[0];
            end
            if (finish) begin
                spi_enable            <= 1'b0;
                spi_start_transaction <= 1'b0;
                rsp_valid             <= last_grant ? 2'b10 : 2'b01;
                rsp_error             <= timed_out;
                rsp_data              <= timed_out ? 8'h00 : spi_incoming_data;
            end
        end
    end

endmodule

// File: tb/tb_spi_transaction_arbiter.sv
// Bench for spi_transaction_arbiter: directed vector table, corner-case
// sequences and randomized transactions against a transaction-level model.
module tb_spi_transaction_arbiter;

    localparam int TO  = 16;
    localparam int GAP = 4;

    logic        clk;
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_slave;
    logic [1:0]  req_operation;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic        rsp_error;
    logic [7:0]  rsp_data;
    logic        busy;
    logic        spi_enable;
    logic        spi_start_transaction;
    logic [1:0]  spi_slave;
    logic [15:0] spi_outgoing_data;
    logic        spi_operation;
    logic        spi_end_of_transaction;
    logic [7:0]  spi_incoming_data;

    int checks = 0;
    int errors = 0;

    spi_transaction_arbiter #(
        .TIMEOUT_CYCLES(TO),
        .GAP_CYCLES(GAP),
        .CNT_WIDTH(16)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_slave(req_slave),
        .req_operation(req_operation),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_error(rsp_error),
        .rsp_data(rsp_data),
        .busy(busy),
        .spi_enable(spi_enable),
        .spi_start_transaction(spi_start_transaction),
        .spi_slave(spi_slave),
        .spi_outgoing_data(spi_outgoing_data),
        .spi_operation(spi_operation),
        .spi_end_of_transaction(spi_end_of_transaction),
        .spi_incoming_data(spi_incoming_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [1:0]  mask;
        logic [15:0] d0;
        logic [1:0]  s0;
        logic        o0;
        logic [15:0] d1;
        logic [1:0]  s1;
        logic        o1;
        int          eot;
        logic [7:0]  inb;
        int          eg;
        logic        ee;
        logic [7:0]  erd;
        int          edur;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One complete transaction: request from IDLE, SPI slave reply after
    // 'eot' enable cycles (0 = never), then the gap back to IDLE.
    task automatic run_txn(input string tag, input logic [1:0] mask,
                           input logic [15:0] d0, input logic [1:0] s0, input logic o0,
                           input logic [15:0] d1, input logic [1:0] s1, input logic o1,
                           input int eot, input logic [7:0] inb,
                           input int eg, input logic ee, input logic [7:0] erd, input int edur);
        logic [15:0] ed;
        logic [1:0]  es;
        logic        eo;
        int          n;
        int          hi;
        int          gc;
        logic        stable;
        logic        quiet;
        ed = (eg == 1) ? d1 : d0;
        es = (eg == 1) ? s1 : s0;
        eo = (eg == 1) ? o1 : o0;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".idle"}, 32'(busy), 32'd0);
        req_valid     = mask;
        req_data      = {d1, d0};
        req_slave     = {s1, s0};
        req_operation = {o1, o0};
        @(negedge clk);
        chk({tag, ".ready"}, 32'(req_ready), (eg == 1) ? 32'd2 : 32'd1);
        chk({tag, ".cmd"}, 32'({spi_outgoing_data, spi_slave, spi_operation}), 32'({ed, es, eo}));
        chk({tag, ".busy"}, 32'({busy, spi_enable}), 32'd3);
        req_valid[eg] = 1'b0;
        req_data      = $urandom;
        req_slave     = 4'($urandom);
        req_operation = 2'($urandom);
        hi = 0;
        stable = 1'b1;
        while (spi_start_transaction && hi < 100) begin
            hi++;
            if (!spi_enable || spi_outgoing_data !== ed || spi_slave !== es ||
                spi_operation !== eo || rsp_valid !== 2'b00 || (hi > 1 && req_ready !== 2'b00))
                stable = 1'b0;
            spi_incoming_data      = (hi == eot) ? inb : 8'($urandom);
            spi_end_of_transaction = (hi == eot);
            @(negedge clk);
            spi_end_of_transaction = 1'b0;
        end
        chk({tag, ".stable"}, 32'(stable), 32'd1);
        chk({tag, ".dur"}, hi, edur);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), (eg == 1) ? 32'd2 : 32'd1);
        chk({tag, ".rsp"}, 32'({rsp_error, rsp_data}), 32'({ee, erd}));
        chk({tag, ".en_off"}, 32'({spi_enable, req_ready}), 32'd0);
        gc = 0;
        quiet = 1'b1;
        while (busy && gc < 50) begin
            gc++;
            if ((gc > 1 && rsp_valid !== 2'b00) || spi_enable) quiet = 1'b0;
            spi_incoming_data      = 8'($urandom);
            spi_end_of_transaction = (gc == 2);
            @(negedge clk);
            spi_end_of_transaction = 1'b0;
        end
        chk({tag, ".gap"}, gc, GAP);
        chk({tag, ".gap_quiet"}, 32'(quiet), 32'd1);
        chk({tag, ".hold"}, 32'({rsp_error, rsp_data}), 32'({ee, erd}));
    endtask

    initial begin
        int          n;
        logic        quiet;
        logic        m_last;
        logic [1:0]  mask;
        int          eot;
        int          g;
        logic        to;
        logic [7:0]  inb;
        logic [15:0] d0, d1;
        logic [1:0]  s0, s1;
        logic        o0, o1;

        reset_n = 1'b0;
        req_valid = '0;
        req_data = '0;
        req_slave = '0;
        req_operation = '0;
        spi_end_of_transaction = 1'b0;
        spi_incoming_data = '0;

        //        mask   d0       s0  o0  d1       s1  o1  eot inb    g  err erd    dur
        tbl[0] = '{2'b11, 16'h1111, 2'd0, 1'b0, 16'h2222, 2'd1, 1'b1, 5,  8'h11, 0, 1'b0, 8'h11, 5};
        tbl[1] = '{2'b11, 16'h3333, 2'd2, 1'b1, 16'h4444, 2'd3, 1'b0, 8,  8'h22, 1, 1'b0, 8'h22, 8};
        tbl[2] = '{2'b11, 16'h5555, 2'd1, 1'b0, 16'h6666, 2'd2, 1'b1, 1,  8'h33, 0, 1'b0, 8'h33, 1};
        tbl[3] = '{2'b11, 16'h7777, 2'd3, 1'b1, 16'h8888, 2'd0, 1'b0, 12, 8'h44, 1, 1'b0, 8'h44, 12};
        tbl[4] = '{2'b01, 16'h1305, 2'd2, 1'b1, 16'h0000, 2'd0, 1'b0, 10, 8'hA5, 0, 1'b0, 8'hA5, 10};
        tbl[5] = '{2'b01, 16'h1305, 2'd2, 1'b1, 16'h0000, 2'd0, 1'b0, 20, 8'hA5, 0, 1'b1, 8'h00, 16};
        tbl[6] = '{2'b10, 16'h0000, 2'd0, 1'b0, 16'hBEEF, 2'd1, 1'b1, 16, 8'h5A, 1, 1'b0, 8'h5A, 16};
        tbl[7] = '{2'b01, 16'hCAFE, 2'd3, 1'b0, 16'h0000, 2'd0, 1'b0, 0,  8'hFF, 0, 1'b1, 8'h00, 16};
        tbl[8] = '{2'b11, 16'h0F0F, 2'd0, 1'b1, 16'hF0F0, 2'd3, 1'b0, 2,  8'h99, 1, 1'b0, 8'h99, 2};

        repeat (2) @(negedge clk);
        chk("rst.ctl", 32'({req_ready, rsp_valid, rsp_error, busy, spi_enable, spi_start_transaction}), 32'd0);
        chk("rst.data", 32'({rsp_data, spi_slave, spi_outgoing_data, spi_operation}), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Stray completion while idle must be ignored.
        spi_incoming_data = 8'h5E;
        spi_end_of_transaction = 1'b1;
        @(negedge clk);
        spi_end_of_transaction = 1'b0;
        chk("stray_idle.rsp", 32'({rsp_valid, rsp_error, rsp_data}), 32'd0);
        @(negedge clk);
        chk("stray_idle.state", 32'({busy, spi_enable, rsp_valid}), 32'd0);

        for (int i = 0; i < 9; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i].mask, tbl[i].d0, tbl[i].s0, tbl[i].o0,
                    tbl[i].d1, tbl[i].s1, tbl[i].o1, tbl[i].eot, tbl[i].inb,
                    tbl[i].eg, tbl[i].ee, tbl[i].erd, tbl[i].edur);
        end
        req_valid = '0;

        // Reset in the middle of a transaction.
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        req_valid = 2'b01;
        req_data = 32'h0000_4242;
        @(negedge clk);
        chk("rstbusy.pre", 32'({busy, spi_enable}), 32'd3);
        req_valid = '0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rstbusy.async", 32'({busy, spi_enable, spi_start_transaction}), 32'd0);
        chk("rstbusy.outs", 32'({spi_outgoing_data, req_ready, rsp_valid}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid !== 2'b00 || busy) quiet = 1'b0;
            @(negedge clk);
        end
        chk("rstbusy.quiet", 32'(quiet), 32'd1);
        run_txn("tie_after_rst", 2'b11, 16'hABCD, 2'd1, 1'b1, 16'hDCBA, 2'd2, 1'b0,
                7, 8'hC3, 0, 1'b0, 8'hC3, 7);

        // Randomized transactions against the transaction-level model.
        m_last = 1'b0;
        for (int i = 0; i < 30; i++) begin
            mask = 2'($urandom_range(1, 3));
            eot  = $urandom_range(0, 20);
            inb  = 8'($urandom);
            d0 = 16'($urandom);  d1 = 16'($urandom);
            s0 = 2'($urandom);   s1 = 2'($urandom);
            o0 = 1'($urandom);   o1 = 1'($urandom);
            if (mask == 2'b11) g = m_last ? 0 : 1;
            else g = (mask == 2'b10) ? 1 : 0;
            m_last = (g == 1);
            to = (eot == 0 || eot > TO);
            run_txn($sformatf("rnd%0d", i), mask, d0, s0, o0, d1, s1, o1, eot, inb,
                    g, to, to ? 8'h00 : inb, to ? TO : eot);
            req_valid = '0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
